// File: rtl/reg_dst_scoreboard.sv
// Register-write scoreboard: one pending bit per architectural register, used to
// interlock issue against outstanding writes (RAW/WAW) without forwarding.
module reg_dst_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int CW   = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            issue_valid,
  input  logic            issue_we,
  input  logic [AW-1:0]   issue_dst,
  input  logic [AW-1:0]   issue_rs,
  input  logic            issue_use_rs,
  input  logic [AW-1:0]   issue_rt,
  input  logic            issue_use_rt,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_dst,
  output logic            stall,
  output logic [NREG-1:0] pending,
  output logic [CW-1:0]   pend_count,
  output logic            err
);

  logic            raw;
  logic            waw;
  logic            set_en;
  logic            clr_en;
  logic            err_ev;
  logic            inc;
  logic            dec;
  logic [NREG-1:0] pending_nxt;

  always_comb begin
    raw    = (issue_use_rs & pending[issue_rs]) | (issue_use_rt & pending[issue_rt]);
    waw    = issue_we & (issue_dst != '0) & pending[issue_dst];
    stall  = issue_valid & (raw | waw);
    set_en = issue_valid & ~stall & issue_we & (issue_dst != '0);
    clr_en = wb_valid & pending[wb_dst];
    err_ev = wb_valid & ~pending[wb_dst] & (wb_dst != '0);
    // A set colliding with a write-back to the same register loses to the clear,
    // so the count only moves when the set actually lands.
    inc    = set_en & ~(wb_valid & (wb_dst == issue_dst));
    dec    = clr_en;
  end

  always_comb begin
    pending_nxt = pending;
    if (set_en) pending_nxt[issue_dst] = 1'b1;
    if (wb_valid) pending_nxt[wb_dst] = 1'b0;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= '0;
      pend_count <= '0;
      err        <= 1'b0;
    end else if (flush) begin
      pending    <= '0;
      pend_count <= '0;
    end else begin
      pending <= pending_nxt;
      if (inc & ~dec)
        pend_count <= pend_count + CW'(1);
      else if (dec & ~inc)
        pend_count <= pend_count - CW'(1);
      if (err_ev) err <= 1'b1;
    end
  end

endmodule
